pref_issue_queue: RTL

PREF_ISSUE_QUEUE -- requirements
Module: pref_issue_queue

---
 rtl/pref_pkg.sv | 13 +
 rtl/pref_hist_cam.sv | 44 ++++
 rtl/pref_issue_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/pref_pkg.sv
// Shared definitions for the prefetch issue path: address width, default line
// size and the line-alignment helper used before every compare or store.
package pref_pkg;

  localparam int ADDR_W        = 64;
  localparam int LINE_BITS_DEF = 6;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr,
                                                   input int unsigned line_bits);
    return addr & ~((ADDR_W'(1) << line_bits) - ADDR_W'(1));
  endfunction

endpackage

// File: rtl/pref_hist_cam.sv
// Small fully-associative history of recently issued lines: one circular write
// port, four parallel compare ports.
module pref_hist_cam
  import pref_pkg::*;
#(
  parameter int HIST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_line,
  input  logic [ADDR_W-1:0] cmp_line [4],
  output logic [3:0]        hit
);

  localparam int PW = (HIST > 1) ? $clog2(HIST) : 1;

  logic [ADDR_W-1:0] lines [HIST];
  logic [HIST-1:0]   valid;
  logic [PW-1:0]     ptr;

  // Oldest entry is the one the pointer sits on, so writes overwrite it.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      valid <= '0;
      ptr   <= '0;
    end else if (wr_en) begin
      lines[ptr] <= wr_line;
      valid[ptr] <= 1'b1;
      ptr        <= (ptr == PW'(HIST - 1)) ? '0 : ptr + PW'(1);
    end
  end

  always_comb begin
    hit = '0;
    for (int p = 0; p < 4; p++) begin
      for (int h = 0; h < HIST; h++) begin
        if (valid[h] && (lines[h] == cmp_line[p])) hit[p] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pref_issue_queue.sv
// Prefetch issue queue: filters up to three line candidates per cycle against
// queue and history, enqueues survivors in priority order, issues in FIFO order.
module pref_issue_queue
  import pref_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int HIST      = 4,
  parameter int LINE_BITS = LINE_BITS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        pref_addr1_i,
  input  logic [ADDR_W-1:0]        pref_addr2_i,
  input  logic [ADDR_W-1:0]        pref_addr3_i,
  input  logic                     pref_valid1_i,
  input  logic                     pref_valid2_i,
  input  logic                     pref_valid3_i,
  input  logic                     flush_i,
  output logic                     req_valid_o,
  output logic [ADDR_W-1:0]        req_addr_o,
  input  logic                     req_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [15:0]              drop_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ADDR_W-1:0] q [DEPTH];
  logic [AW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;
  logic [15:0]       drop_cnt;

  logic [ADDR_W-1:0] cand_addr [3];
  logic [ADDR_W-1:0] cand_line [3];
  logic [ADDR_W-1:0] cmp_line  [4];
  logic [AW-1:0]     push_idx  [3];
  logic [2:0]        cand_valid, in_q, surv, push_en;
  logic [DEPTH-1:0]  occ;
  logic [3:0]        hist_hit;
  logic [CW-1:0]     free, n_push;
  logic [1:0]        n_drop;
  logic [16:0]       drop_sum;
  logic              pop;

  assign cand_addr[0] = pref_addr1_i;
  assign cand_addr[1] = pref_addr2_i;
  assign cand_addr[2] = pref_addr3_i;
  assign cand_valid   = {pref_valid3_i, pref_valid2_i, pref_valid1_i};

  assign pop      = (count != '0) & req_ready_i;
  assign free     = CW'(DEPTH) - count + CW'(pop);
  assign drop_sum = {1'b0, drop_cnt} + 17'(n_drop);

  assign cmp_line[0] = cand_line[0];
  assign cmp_line[1] = cand_line[1];
  assign cmp_line[2] = cand_line[2];
  assign cmp_line[3] = q[rd_ptr];

  // The head still counts as occupied while it is being popped, so a candidate
  // matching it is filtered rather than re-queued.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      occ[e] = CW'(AW'(AW'(e) - rd_ptr)) < count;
    end
    for (int i = 0; i < 3; i++) begin
      cand_line[i] = line_align(cand_addr[i], LINE_BITS);
      in_q[i]      = 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        if (occ[e] && (q[e] == cand_line[i])) in_q[i] = 1'b1;
      end
    end

    surv[0] = cand_valid[0] & ~in_q[0] & ~hist_hit[0];
    surv[1] = cand_valid[1] & ~in_q[1] & ~hist_hit[1]
            & ~(surv[0] & (cand_line[1] == cand_line[0]));
    surv[2] = cand_valid[2] & ~in_q[2] & ~hist_hit[2]
            & ~(surv[0] & (cand_line[2] == cand_line[0]))
            & ~(surv[1] & (cand_line[2] == cand_line[1]));

    n_push  = '0;
    n_drop  = '0;
    push_en = '0;
    for (int i = 0; i < 3; i++) begin
      push_idx[i] = wr_ptr + n_push[AW-1:0];
      if (surv[i]) begin
        if (n_push < free) begin
          push_en[i] = 1'b1;
          n_push     = n_push + CW'(1);
        end else begin
          n_drop = n_drop + 2'd1;
        end
      end
    end
  end

  // Flush drops queue contents and pending traffic but keeps the drop statistic.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int e = 0; e < DEPTH; e++) q[e] <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push_en[i]) q[push_idx[i]] <= cand_line[i];
      end
      wr_ptr   <= wr_ptr + n_push[AW-1:0];
      rd_ptr   <= rd_ptr + AW'(pop);
      count    <= count + n_push - CW'(pop);
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  pref_hist_cam #(.HIST(HIST)) u_hist (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (flush_i),
    .wr_en    (pop & ~flush_i & ~hist_hit[3]),
    .wr_line  (q[rd_ptr]),
    .cmp_line (cmp_line),
    .hit      (hist_hit)
  );

  assign req_valid_o = (count != '0);
  assign req_addr_o  = q[rd_ptr];
  assign count_o     = count;
  assign drop_cnt_o  = drop_cnt;

endmodule
